// File: rtl/pipelined_nbit_adder.sv
// Pipelined add/subtract: one STAGE_W-bit ripple slice per stage, with the carry registered between slices.
// A single global stall (advance) freezes every stage, so a result held at the output never changes.

module add_slice #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
endmodule

module pipelined_nbit_adder #(
  parameter int WIDTH   = 16,
  parameter int STAGE_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_Sum,
  output logic             o_Cout,
  output logic             o_Ovf
);
  localparam int STAGES = WIDTH / STAGE_W;

  logic               advance;
  logic [STAGES-1:0]  vld_q;
  logic [STAGES:0]    vld_pipe;
  logic [WIDTH-1:0]   b_eff;
  logic               c_eff;

  // Subtraction is A + ~B + ~Cin, so Cout = 1 means "no borrow".
  assign b_eff    = i_sub ? ~i_B : i_B;
  assign c_eff    = i_sub ^ i_Cin;
  assign vld_pipe = {vld_q, i_valid};
  assign o_valid  = vld_pipe[STAGES];
  assign advance  = ~o_valid | i_ready;
  assign o_ready  = advance;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)   vld_q <= '0;
    else if (advance) vld_q <= vld_pipe[STAGES-1:0];
  end

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO = k * STAGE_W;
    localparam int HI = (k + 1) * STAGE_W;

    logic [WIDTH-LO-1:0] a_in, b_in;
    logic                c_in;
    logic [STAGE_W-1:0]  s;
    logic                co;
    logic [HI-1:0]       sum_d, sum_q;
    logic                c_q;
    logic                load;

    // Operands shrink by one slice per stage; only the unsummed upper part travels on.
    if (k == 0) begin : g_first
      assign a_in  = i_A;
      assign b_in  = b_eff;
      assign c_in  = c_eff;
      assign sum_d = s;
    end else begin : g_next
      assign a_in  = stg[k-1].g_fwd.a_q;
      assign b_in  = stg[k-1].g_fwd.b_q;
      assign c_in  = stg[k-1].c_q;
      assign sum_d = {s, stg[k-1].sum_q};
    end

    add_slice #(.SW(STAGE_W)) u_slice (
      .a    (a_in[STAGE_W-1:0]),
      .b    (b_in[STAGE_W-1:0]),
      .cin  (c_in),
      .s    (s),
      .cout (co)
    );

    // Bubbles leave the data registers untouched, so o_Sum keeps the last real result.
    assign load = advance & vld_pipe[k];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (load) begin
        sum_q <= sum_d;
        c_q   <= co;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-HI-1:0] a_q, b_q;
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load) begin
          a_q <= a_in[WIDTH-LO-1:STAGE_W];
          b_q <= b_in[WIDTH-LO-1:STAGE_W];
        end
      end
    end else begin : g_last
      logic ovf_q;
      // Carry into the MSB is recovered as s ^ a ^ b at that bit.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) ovf_q <= 1'b0;
        else if (load)  ovf_q <= s[STAGE_W-1] ^ a_in[STAGE_W-1] ^ b_in[STAGE_W-1] ^ co;
      end
    end
  end

  assign o_Sum  = stg[STAGES-1].sum_q;
  assign o_Cout = stg[STAGES-1].c_q;
  assign o_Ovf  = stg[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_pipelined_nbit_adder.sv
// Checks three adder configurations (16/4, 8/8, 32/4) against an arithmetic model with in-order queues,
// plus literal corner cases, latency, stall stability and mid-stream reset.

module tb_pipelined_nbit_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        v16, rd16, c16, s16, ov16, ir16, co16, of16;
  logic [15:0] a16, b16, sum16;
  logic        v8, rd8, c8, s8, ov8, ir8, co8, of8;
  logic [7:0]  a8, b8, sum8;
  logic        v32, rd32, c32, s32, ov32, ir32, co32, of32;
  logic [31:0] a32, b32, sum32;
  logic [33:0] res16, res8, res32;

  assign res16 = {of16, co16, 16'h0, sum16};
  assign res8  = {of8, co8, 24'h0, sum8};
  assign res32 = {of32, co32, sum32};

  pipelined_nbit_adder #(.WIDTH(16), .STAGE_W(4)) u_dut16 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(v16), .o_ready(rd16), .i_A(a16), .i_B(b16),
    .i_Cin(c16), .i_sub(s16), .o_valid(ov16), .i_ready(ir16), .o_Sum(sum16), .o_Cout(co16), .o_Ovf(of16));
  pipelined_nbit_adder #(.WIDTH(8), .STAGE_W(8)) u_dut8 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(v8), .o_ready(rd8), .i_A(a8), .i_B(b8),
    .i_Cin(c8), .i_sub(s8), .o_valid(ov8), .i_ready(ir8), .o_Sum(sum8), .o_Cout(co8), .o_Ovf(of8));
  pipelined_nbit_adder #(.WIDTH(32), .STAGE_W(4)) u_dut32 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(v32), .o_ready(rd32), .i_A(a32), .i_B(b32),
    .i_Cin(c32), .i_sub(s32), .o_valid(ov32), .i_ready(ir32), .o_Sum(sum32), .o_Cout(co32), .o_Ovf(of32));

  // Reference: {ovf, cout, sum zero-extended to 32} from plain integer arithmetic.
  function automatic logic [33:0] model(int w, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    longint m, half, ua, ub, c, r, sa, sb, t;
    logic [33:0] o;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = sub ? (~longint'(b)) & m : longint'(b) & m;
    c    = (sub ? ~cin : cin) ? 1 : 0;
    r    = ua + ub + c;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    t    = sa + sb + c;
    o[31:0] = 32'(r & m);
    o[32]   = ((r >> w) & 1) != 0;
    o[33]   = (t >= half) || (t < -half);
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic extra(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: result beat with no outstanding input beat", nm);
  endtask

  logic [33:0] q16[$], q8[$], q32[$];
  logic [33:0] hold_val;
  logic        held = 1'b0;
  int          acc16 = 0;

  // Compare processes: sample mid-cycle, when handshakes for the coming edge are settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      q16.delete();
      held = 1'b0;
    end else begin
      if (held) chk("stall hold16", {ov16, res16}, {1'b1, hold_val});
      if (ov16 && ir16) begin
        if (q16.size() == 0) extra("extra16");
        else chk("stream16", res16, q16.pop_front());
      end
      if (v16 && rd16) begin
        q16.push_back(model(16, {16'h0, a16}, {16'h0, b16}, c16, s16));
        acc16++;
      end
      held     = ov16 && !ir16;
      hold_val = res16;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
      q32.delete();
    end else begin
      if (ov8 && ir8) begin
        if (q8.size() == 0) extra("extra8");
        else chk("stream8", res8, q8.pop_front());
      end
      if (v8 && rd8) q8.push_back(model(8, {24'h0, a8}, {24'h0, b8}, c8, s8));
      if (ov32 && ir32) begin
        if (q32.size() == 0) extra("extra32");
        else chk("stream32", res32, q32.pop_front());
      end
      if (v32 && rd32) q32.push_back(model(32, a32, b32, c32, s32));
    end
  end

  task automatic drive(input int d, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub);
    case (d)
      0: begin v16 = v; a16 = a[15:0]; b16 = b[15:0]; c16 = cin; s16 = sub; end
      1: begin v8  = v; a8  = a[7:0];  b8  = b[7:0];  c8  = cin; s8  = sub; end
      default: begin v32 = v; a32 = a; b32 = b; c32 = cin; s32 = sub; end
    endcase
  endtask

  function automatic logic out_valid(int d);
    return (d == 0) ? ov16 : (d == 1) ? ov8 : ov32;
  endfunction

  function automatic logic [33:0] out_res(int d);
    return (d == 0) ? res16 : (d == 1) ? res8 : res32;
  endfunction

  // One beat into an idle pipe with i_ready high; checks latency and the literal result.
  task automatic directed(input int d, input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, input logic [33:0] exp, input int exp_lat, input string nm);
    int lat;
    @(posedge clk); #1;
    drive(d, 1'b1, a, b, cin, sub);
    @(posedge clk); #1;
    drive(d, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
    lat = 1;
    while (!out_valid(d) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " result"}, 64'(out_res(d)), 64'(exp));
  endtask

  task automatic drain(input string nm);
    int cyc;
    v16 = 0; v8 = 0; v32 = 0; ir16 = 1; ir8 = 1; ir32 = 1;
    cyc = 0;
    while ((q16.size() + q8.size() + q32.size()) != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " outstanding"}, 64'(q16.size() + q8.size() + q32.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    drive(0, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(2, 1'b0, 0, 0, 1'b0, 1'b0);
    ir16 = 1; ir8 = 1; ir32 = 1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset o_valid", 64'(ov16), 64'd0);
    chk("reset o_Sum/Cout/Ovf", 64'(res16), 64'd0);
    chk("reset o_ready", 64'(rd16), 64'd1);
    chk("reset o_valid32", 64'(ov32), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    directed(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000},     4, "ffff+1");
    directed(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000},     4, "7fff+1");
    directed(0, 32'h8000, 32'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF},     4, "8000-1");
    directed(0, 32'h0005, 32'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFE},     4, "5-7");
    directed(0, 32'h0005, 32'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFD},     4, "5-7-1");

    // Random stream with random valid and back-pressure.
    acc16 = 0;
    cyc   = 0;
    while (acc16 < 200 && cyc < 5000) begin
      drive(0, $urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom), 1'($urandom));
      ir16 = $urandom_range(0, 2) != 0;
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream16 beats accepted", 64'(acc16 >= 200), 64'd1);
    drain("stream16");

    // Reset with three beats in flight.
    repeat (3) begin
      drive(0, 1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom));
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset o_valid", 64'(ov16), 64'd0);
    chk("midreset o_Sum/Cout/Ovf", 64'(res16), 64'd0);
    chk("midreset o_ready", 64'(rd16), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    directed(0, 32'h1234, 32'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 32'h2345},     4, "post-reset");
    repeat (8) @(posedge clk);
    #1;

    directed(1, 32'h7F, 32'h01, 1'b0, 1'b0, {1'b1, 1'b0, 32'h80},           1, "w8 7f+1");
    directed(1, 32'hFF, 32'h01, 1'b1, 1'b0, {1'b0, 1'b1, 32'h01},           1, "w8 ff+1+1");
    directed(1, 32'h05, 32'h07, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFE},           1, "w8 5-7");
    directed(2, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0},        8, "w32 ffffffff+1");
    directed(2, 32'h80000000, 32'h1, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFFFFFF}, 8, "w32 80000000-1");

    for (int i = 0; i < 2500; i++) begin
      drive(1, $urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom), 1'($urandom));
      drive(2, $urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom), 1'($urandom));
      ir8  = $urandom_range(0, 3) != 0;
      ir32 = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    drain("sweep");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
